// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_adder_pkg                                              |
// | Purpose  : Shared definitions for the bit-serial adder:                  |
// |            FSM state encoding and default operand width.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fa                                                            |
// | Purpose  : Gate-level one-bit full adder, purely combinational.          |
// | Ports    : a, b  - addend bits                                           |
// |            c     - carry in                                              |
// |            sum   - a ^ b ^ c                                             |
// |            carry - majority(a, b, c)                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic w_axb;
  logic w_ab;
  logic w_cx;

  xor u_x1 (w_axb, a, b);
  xor u_x2 (sum, w_axb, c);
  and u_a1 (w_ab, a, b);
  and u_a2 (w_cx, c, w_axb);
  or  u_o1 (carry, w_ab, w_cx);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_adder                                                  |
// | Purpose  : Bit-serial WIDTH-bit adder. Operands and carry-in are latched |
// |            on an accepted start, then one bit pair per clock (LSB first) |
// |            is fed through a single fa cell. Result is valid with done.   |
// | Ports    : clk, rst_n       - clock, async active-low reset              |
// |            start            - request strobe (ignored while busy)        |
// |            a, b, cin        - operands, captured on accepted start       |
// |            busy             - high while bits are processed              |
// |            done             - one-cycle pulse, result valid              |
// |            sum, cout        - result, held until next accepted start     |
// |            ovf              - signed overflow (SERIAL_ADDER_OVF_EN only) |
// | Config   : define SERIAL_ADDER_OVF_EN to add the ovf output.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_sum;
  logic               fa_carry;
  logic               last_bit;
  logic               accept;

  fa u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt_q == CNT_LAST);
  // A new request is only honoured when the datapath is free.
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      RUN: begin
        // Result fills from the top so that after WIDTH shifts the first
        // processed bit lands in bit 0.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (last_bit) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this final bit.
          ovf_d   = carry_q ^ fa_carry;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_adder                                               |
// | Purpose  : Directed self-checking bench for serial_adder (WIDTH=8).      |
// |            Define SERIAL_ADDER_OVF_EN to also check the ovf output.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int LAT   = 8;
  localparam int BUDGET = 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a start at the negedge, release it 1 ns after the accepting edge.
  task automatic start_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; returns BUDGET+1 on timeout.
  task automatic wait_done(output int n);
    n = BUDGET + 1;
    for (int i = 1; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int n;
    start_op(va, vb, vc);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    check({tag, "_lat"}, n, LAT);
    check({tag, "_nobusy"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo) begin end
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, {23'd0, cout, sum}, {23'd0, ec, es});
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",  {31'd0, ovf},  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic sums and carry boundaries.
    run_op("add0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("addffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    // Signed overflow cases (sum/cout are checked in every build).
    run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("add1234", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Start held through RUN with operands changing each cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h21;
    b     = 8'h42;
    cin   = 1'b1;
    n     = BUDGET + 1;
    for (int i = 0; i <= BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    check("hold_lat", n, LAT);
    check("hold_sum", {23'd0, cout, sum}, 32'h064);
    @(posedge clk);
    #1;

    // Back-to-back: new start presented in the DONE cycle.
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(n);
    check("b2b_lat1", n, LAT);
    check("b2b_sum1", {24'd0, sum}, 32'h30);
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("b2b_lat2", n, LAT);
    check("b2b_sum2", {23'd0, cout, sum}, 32'h007);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN.
    start_op(8'hFF, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sum",  {24'd0, sum},  32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("mid_rst_quiet", {31'd0, seen}, 32'd0);
    run_op("post_rst", 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
